// File: rtl/aluop_decode_stage.sv
// aluop_decode_stage: decodes the RV32 opcode of each accepted instruction into
// an ALU operation code plus ALU control bits, behind a valid/ready stage with a
// 2-entry buffer (output entry + skid entry) and a saturating illegal counter.
// Optional feature: define ALUOP_DECODE_MEXT_EN to decode the M extension
// (R-type with funct7 = 0000001) and drive mext_o; otherwise those are illegal.
//
// Handshake: a beat moves on a rising edge when valid and ready are both high.
// in_valid_i/instr_i are sampled only when in_ready_o is high; out_valid_o and
// the decoded outputs stay stable until out_ready_i is seen high.
module aluop_decode_stage #(
  parameter int INSTR_W = 32,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic [3:0]         alu_ctrl_o,
  output logic               illegal_o,
  output logic               mext_o,
  input  logic               flush_i,
  input  logic               clr_cnt_i,
  output logic [CNT_W-1:0]   illegal_cnt_o
);

  typedef struct packed {
    logic [2:0] aluop;
    logic [3:0] ctrl;
    logic       ill;
    logic       mext;
  } entry_t;

  entry_t           dec;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic [2:0]       funct3;
  logic             unused_instr;

  // Bits of the instruction the decoder never looks at (rd, rs1, rs2).
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};
  assign funct3       = instr_i[14:12];

  // Combinational opcode decode of the incoming instruction.
  always_comb begin
    dec = '0;
    unique case (instr_i[6:0])
      7'b0110011: begin
        if (instr_i[31:25] == 7'b0000001) begin
`ifdef ALUOP_DECODE_MEXT_EN
          dec.mext = 1'b1;
          dec.ctrl = {1'b0, funct3};
`else
          dec.ill  = 1'b1;
`endif
        end else begin
          dec.ctrl = {instr_i[30], funct3};
        end
      end
      7'b0010011: begin
        dec.aluop = 3'b001;
        // Only the shift-right immediate uses bit 30 (srli vs srai).
        dec.ctrl  = (funct3 == 3'b101) ? {instr_i[30], funct3} : {1'b0, funct3};
      end
      7'b1100011: begin
        dec.aluop = 3'b010;
        dec.ctrl  = {1'b0, funct3};
      end
      7'b1101111, 7'b1100111: dec.aluop = 3'b011;
      7'b0000011:             dec.aluop = 3'b100;
      7'b0100011:             dec.aluop = 3'b101;
      7'b0110111:             dec.aluop = 3'b110;
      7'b0010111:             dec.aluop = 3'b111;
      default:                dec.ill   = 1'b1;
    endcase
  end

  assign accept = in_valid_i & in_ready_q;

  // Next-state for the two buffer entries, the ready flag and the counter.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;

    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready_i) begin
      // Output entry is free this edge: refill from skid first, then input.
      // in_ready_q is low whenever skid is full, so both cannot compete.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (accept && dec.ill && !flush_i && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    in_ready_d = !skid_valid_d;
  end

  // State registers, asynchronously cleared by rst_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o    = in_ready_q;
  assign out_valid_o   = out_valid_q;
  assign aluop_o       = out_valid_q ? ALUOP_W'(out_q.aluop) : '0;
  assign alu_ctrl_o    = out_valid_q ? out_q.ctrl : 4'b0000;
  assign illegal_o     = out_valid_q & out_q.ill;
  assign mext_o        = out_valid_q & out_q.mext;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_aluop_decode_stage.sv
// Bench for aluop_decode_stage: decode table, hand-written stall/flush/reset
// sequences and randomized traffic, all checked against a queue-based model.
module tb_aluop_decode_stage;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [6:0] OPC_TAB [9] = '{7'h33, 7'h13, 7'h63, 7'h6F, 7'h67,
                                         7'h03, 7'h23, 7'h37, 7'h17};
  localparam int CODE_TAB [9] = '{0, 1, 2, 3, 3, 4, 5, 6, 7};

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       aluop;
  logic [3:0]       alu_ctrl;
  logic             illegal;
  logic             mext;
  logic             flush;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt;

  int total;
  int bad;

  // Model: pending entries {aluop, ctrl, ill, mext}, oldest first.
  logic [8:0] exp_q[$];
  int         mcnt;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  aluop;
    logic [3:0]  ctrl;
    logic        ill;
    logic        mext;
  } vec_t;

  vec_t vecs[16];

  aluop_decode_stage #(
    .INSTR_W(32),
    .ALUOP_W(3),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .instr_i      (instr),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .aluop_o      (aluop),
    .alu_ctrl_o   (alu_ctrl),
    .illegal_o    (illegal),
    .mext_o       (mext),
    .flush_i      (flush),
    .clr_cnt_i    (clr_cnt),
    .illegal_cnt_o(cnt)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode from the opcode table and the alu_ctrl rules.
  function automatic logic [8:0] ref_decode(input logic [31:0] ins);
    int code = -1;
    int f3   = int'(ins[14:12]);
    int hi   = int'(ins[30]);
    int ctrl = 0;
    for (int i = 0; i < 9; i++)
      if (ins[6:0] == OPC_TAB[i]) code = CODE_TAB[i];
    if (code < 0) return 9'b000_0000_10;
    if (code == 0 && ins[31:25] == 7'b0000001) begin
`ifdef ALUOP_DECODE_MEXT_EN
      return {3'd0, 4'(f3), 1'b0, 1'b1};
`else
      return 9'b000_0000_10;
`endif
    end
    if (code == 0) ctrl = hi * 8 + f3;
    else if (code == 1) ctrl = (f3 == 5) ? hi * 8 + f3 : f3;
    else if (code == 2) ctrl = f3;
    return {3'(code), 4'(ctrl), 1'b0, 1'b0};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    int          idx = $urandom_range(0, 10);
    ins[6:0] = (idx < 9) ? OPC_TAB[idx] : 7'($urandom_range(0, 127));
    if (ins[6:0] == 7'h33) begin
      case ($urandom_range(0, 2))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ins[31:25] = 7'h01;
      endcase
    end
    return ins;
  endfunction

  task automatic check_model();
    logic [8:0] e = (exp_q.size() > 0) ? exp_q[0] : 9'd0;
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    chk("fields", {23'd0, aluop, alu_ctrl, illegal, mext}, {23'd0, e});
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
    chk("illegal_cnt", 32'(cnt), 32'(mcnt));
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic tick();
    logic       acc = in_valid && (exp_q.size() < 2);
    logic [8:0] e   = ref_decode(instr);
    @(posedge clk);
    if (clr_cnt) mcnt = 0;
    else if (acc && e[1] && !flush && mcnt < CNT_MAX) mcnt++;
    if (flush) exp_q.delete();
    else begin
      if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(e);
    end
    #1;
    check_model();
  endtask

  task automatic send(input logic [31:0] ins);
    in_valid = 1'b1;
    instr    = ins;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_valid"}, 32'(out_valid), 32'd0);
    chk({name, "_fields"}, {23'd0, aluop, alu_ctrl, illegal, mext}, 32'd0);
    chk({name, "_ready"}, 32'(in_ready), 32'd1);
    chk({name, "_cnt"}, 32'(cnt), 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0]  = '{32'h00B50533, 3'b000, 4'b0000, 1'b0, 1'b0}; // add
    vecs[1]  = '{32'h00A00093, 3'b001, 4'b0000, 1'b0, 1'b0}; // addi
    vecs[2]  = '{32'h40B50533, 3'b000, 4'b1000, 1'b0, 1'b0}; // sub
    vecs[3]  = '{32'h40155093, 3'b001, 4'b1101, 1'b0, 1'b0}; // srai
    vecs[4]  = '{32'h40151093, 3'b001, 4'b0001, 1'b0, 1'b0}; // I funct3=001, bit30 ignored
    vecs[5]  = '{32'h40B55533, 3'b000, 4'b1101, 1'b0, 1'b0}; // sra
    vecs[6]  = '{32'h00B50463, 3'b010, 4'b0000, 1'b0, 1'b0}; // beq
    vecs[7]  = '{32'h00B51463, 3'b010, 4'b0001, 1'b0, 1'b0}; // bne
    vecs[8]  = '{32'h0000006F, 3'b011, 4'b0000, 1'b0, 1'b0}; // jal
    vecs[9]  = '{32'h00008067, 3'b011, 4'b0000, 1'b0, 1'b0}; // jalr
    vecs[10] = '{32'h0000A103, 3'b100, 4'b0000, 1'b0, 1'b0}; // lw
    vecs[11] = '{32'h0020A023, 3'b101, 4'b0000, 1'b0, 1'b0}; // sw
    vecs[12] = '{32'h000000B7, 3'b110, 4'b0000, 1'b0, 1'b0}; // lui
    vecs[13] = '{32'h00000097, 3'b111, 4'b0000, 1'b0, 1'b0}; // auipc
    vecs[14] = '{32'hFFFFFFFF, 3'b000, 4'b0000, 1'b1, 1'b0}; // illegal
`ifdef ALUOP_DECODE_MEXT_EN
    vecs[15] = '{32'h02B50533, 3'b000, 4'b0000, 1'b0, 1'b1}; // mul
`else
    vecs[15] = '{32'h02B50533, 3'b000, 4'b0000, 1'b1, 1'b0}; // mul, illegal
`endif

    // Reset
    in_valid  = 1'b0;
    instr     = 32'd0;
    out_ready = 1'b1;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    rst       = 1'b1;
    exp_q.delete();
    mcnt = 0;
    #2;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    rst = 1'b0;

    // Decode table, back-to-back with out_ready high.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      instr    = vecs[i].instr;
      tick();
      chk("tbl_valid", 32'(out_valid), 32'd1);
      chk("tbl_fields", {23'd0, aluop, alu_ctrl, illegal, mext},
          {23'd0, vecs[i].aluop, vecs[i].ctrl, vecs[i].ill, vecs[i].mext});
      chk("tbl_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("tbl_drained", 32'(out_valid), 32'd0);

    // Stall: lw then sw while out_ready low, then release.
    out_ready = 1'b0;
    send(32'h0000A103);
    chk("stall_lw", 32'(aluop), 32'd4);
    send(32'h0020A023);
    chk("stall_hold", 32'(aluop), 32'd4);
    chk("stall_ready_low", 32'(in_ready), 32'd0);
    tick();
    chk("stall_hold2", 32'(aluop), 32'd4);
    out_ready = 1'b1;
    tick();
    chk("stall_sw", 32'(aluop), 32'd5);
    chk("stall_ready_back", 32'(in_ready), 32'd1);
    tick();
    chk("stall_empty", 32'(out_valid), 32'd0);

    // Illegal counter saturation and clear-over-increment.
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("cnt_cleared", 32'(cnt), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      send(32'hFFFFFFFF);
      chk("cnt_illegal", 32'(illegal), 32'd1);
      chk("cnt_value", 32'(cnt), 32'((k < 3) ? k : 3));
    end
    clr_cnt = 1'b1;
    send(32'hFFFFFFFF);
    clr_cnt = 1'b0;
    chk("cnt_clr_wins", 32'(cnt), 32'd0);
    tick();

    // Flush with a beat accepted in the same cycle: dropped, not counted.
    out_ready = 1'b0;
    send(32'h00B50533);
    flush = 1'b1;
    send(32'hFFFFFFFF);
    flush = 1'b0;
    chk("flush1_valid", 32'(out_valid), 32'd0);
    chk("flush1_cnt", 32'(cnt), 32'd0);
    // Flush with both entries full.
    send(32'h00B50533);
    send(32'h00A00093);
    chk("flush2_full", 32'(in_ready), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush2_valid", 32'(out_valid), 32'd0);
    chk("flush2_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("flush2_nothing", 32'(out_valid), 32'd0);

    // Reset mid-stall: outputs clear without waiting for a clock edge.
    out_ready = 1'b0;
    send(32'hFFFFFFFF);
    send(32'h0000A103);
    rst      = 1'b1;
    in_valid = 1'b1;
    #1;
    exp_q.delete();
    mcnt = 0;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_reset_outputs("rst_mid_held");
    rst = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      clr_cnt   = ($urandom_range(0, 29) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    clr_cnt   = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
